// File: rtl/oled_pkg.sv
// oled_pkg: sequencer states and panel command bytes shared by the OLED controller
package oled_pkg;
  typedef enum logic [3:0] {
    OFF, VDD_WAIT, RES_LO, RES_HI, INIT_A, VBAT_WAIT, INIT_B, READY, PD_CMD, PD_VBAT, DEAD
  } state_t;
  localparam int N_INIT = 10;
  localparam int N_INIT_A = 5;
  localparam logic [0:N_INIT-1][7:0] INIT_CMDS = {
    8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF
  };
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
endpackage

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: MSB-first byte serialiser, SCLK idles high, SCLK_HALF cycles per phase
module oled_spi_tx #(
  parameter int SCLK_HALF = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dc,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdin,
  output logic       dc_out
);
  logic [7:0] sh;
  logic [7:0] cnt;
  logic [2:0] nbit;
  logic       phase_end;
  assign phase_end = cnt == 8'(SCLK_HALF - 1);
  // done marks the final cycle of the last high phase
  assign done = busy && sclk && phase_end && nbit == 3'd7;
  assign sdin = sh[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      sclk   <= 1'b1;
      sh     <= '0;
      dc_out <= 1'b0;
      cnt    <= '0;
      nbit   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      sclk   <= 1'b0;
      sh     <= data;
      dc_out <= dc;
      cnt    <= '0;
      nbit   <= '0;
    end else if (busy) begin
      cnt <= phase_end ? '0 : cnt + 8'd1;
      if (phase_end && !sclk) sclk <= 1'b1;
      else if (phase_end && nbit == 3'd7) busy <= 1'b0;
      else if (phase_end) begin
        sclk <= 1'b0;
        sh   <= {sh[6:0], 1'b0};
        nbit <= nbit + 3'd1;
      end
    end
  end
endmodule

// File: rtl/oled_ctrl.sv
// oled_ctrl: OLED power-up/init/power-down sequencer with a host byte write port
module oled_ctrl
  import oled_pkg::*;
#(
  parameter int SCLK_HALF = 5,
  parameter int T_VDD     = 100000,
  parameter int T_RES     = 300,
  parameter int T_VBAT    = 10000000
) (
  input  logic       sysclk,
  input  logic       cpu_reset,
  input  logic       wr_valid,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       off_req,
  output logic       init_done,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_vbat,
  output logic       oled_vdd
);
  state_t      state, state_n;
  logic [31:0] cnt;
  logic [3:0]  idx;
  logic        busy, done, start;
  logic [7:0]  tx_data;
  logic        tx_dc;
  assign wr_ready  = state == READY && !busy && !off_req;
  assign init_done = state == READY;
  assign start     = (wr_valid && wr_ready) || (state inside {INIT_A, INIT_B, PD_CMD} && !busy);
  assign tx_data   = state == READY ? wr_data : state == PD_CMD ? CMD_DISPLAY_OFF : INIT_CMDS[idx];
  assign tx_dc     = state == READY && wr_dc;
  always_comb begin
    state_n = state;
    case (state)
      OFF:       state_n = VDD_WAIT;
      VDD_WAIT:  if (cnt == 32'(T_VDD - 1)) state_n = RES_LO;
      RES_LO:    if (cnt == 32'(T_RES - 1)) state_n = RES_HI;
      RES_HI:    if (cnt == 32'(T_RES - 1)) state_n = INIT_A;
      INIT_A:    if (done && idx == 4'(N_INIT_A - 1)) state_n = VBAT_WAIT;
      VBAT_WAIT: if (cnt == 32'(T_VBAT - 1)) state_n = INIT_B;
      INIT_B:    if (done && idx == 4'(N_INIT - 1)) state_n = READY;
      READY:     if (off_req && !busy) state_n = PD_CMD;
      PD_CMD:    if (done) state_n = PD_VBAT;
      PD_VBAT:   if (cnt == 32'(T_VBAT - 1)) state_n = DEAD;
      default:   state_n = state;
    endcase
  end
  // panel supply/reset pins follow the state one cycle later
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state     <= OFF;
      cnt       <= '0;
      idx       <= '0;
      oled_vdd  <= 1'b1;
      oled_vbat <= 1'b1;
      oled_res  <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= state_n != state ? '0 : cnt + 32'd1;
      idx       <= done && state inside {INIT_A, INIT_B} ? idx + 4'd1 : idx;
      oled_vdd  <= state == DEAD;
      oled_vbat <= !(state inside {VBAT_WAIT, INIT_B, READY, PD_CMD});
      oled_res  <= state != RES_LO;
    end
  end
  oled_spi_tx #(.SCLK_HALF(SCLK_HALF)) u_tx (
    .clk   (sysclk),
    .rst   (cpu_reset),
    .start (start),
    .dc    (tx_dc),
    .data  (tx_data),
    .busy  (busy),
    .done  (done),
    .sclk  (oled_sclk),
    .sdin  (oled_sdin),
    .dc_out(oled_dc)
  );
endmodule

// File: tb/tb_oled_ctrl.sv
// tb_oled_ctrl: directed bench for oled_ctrl with SCLK_HALF=2, T_VDD=10, T_RES=4, T_VBAT=20
module tb_oled_ctrl;
  logic       sysclk = 1'b0, cpu_reset = 1'b1, wr_valid = 1'b0, wr_dc = 1'b0, off_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, oled_dc, oled_res, oled_sclk, oled_sdin, oled_vbat, oled_vdd;
  logic [7:0] outs;
  int         tests = 0, fails = 0, cyc = 0, dc_err = 0;
  logic [7:0] bytes[$];
  logic       dcs[$];
  logic [7:0] mon_sh = 8'h00;
  int         mon_n = 0;
  logic       mon_dc = 1'b0, psclk = 1'b1;
  localparam logic [7:0] EXP_INIT [10] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
  localparam logic [7:0] RST_OUTS = 8'b1111_0000;

  oled_ctrl #(.SCLK_HALF(2), .T_VDD(10), .T_RES(4), .T_VBAT(20)) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .wr_valid(wr_valid), .wr_dc(wr_dc), .wr_data(wr_data),
    .wr_ready(wr_ready), .off_req(off_req), .init_done(init_done), .oled_dc(oled_dc), .oled_res(oled_res),
    .oled_sclk(oled_sclk), .oled_sdin(oled_sdin), .oled_vbat(oled_vbat), .oled_vdd(oled_vdd)
  );

  always #5 sysclk = ~sysclk;
  assign outs = {oled_vdd, oled_vbat, oled_res, oled_sclk, oled_sdin, oled_dc, wr_ready, init_done};

  // decode the serial link: a bit is taken on each rising SCLK
  always @(negedge sysclk) begin
    if (cpu_reset) mon_n = 0;
    else if (oled_sclk && !psclk) begin
      if (mon_n == 0) mon_dc = oled_dc;
      else if (oled_dc !== mon_dc) dc_err++;
      mon_sh = {mon_sh[6:0], oled_sdin};
      mon_n++;
      if (mon_n == 8) begin
        bytes.push_back(mon_sh);
        dcs.push_back(mon_dc);
        mon_n = 0;
      end
    end
    psclk = oled_sclk;
  end

  task tick;
    @(negedge sysclk);
    cyc++;
  endtask

  task release_reset;
    @(posedge sysclk);
    #1 cpu_reset = 1'b0;
    bytes.delete();
    dcs.delete();
    dc_err = 0;
    @(negedge sysclk);
    cyc = 0;
  endtask

  task test_reset;
    cpu_reset = 1'b1;
    repeat (3) tick;
    tests++;
    if (outs !== RST_OUTS) begin fails++; $display("FAIL reset_outs: got %b expected %b", outs, RST_OUTS); end
    release_reset;
    tests++;
    if (oled_vdd !== 1'b1) begin fails++; $display("FAIL vdd_c0: got %b expected 1", oled_vdd); end
    tick;
    tests++;
    if (oled_vdd !== 1'b0) begin fails++; $display("FAIL vdd_c1: got %b expected 0", oled_vdd); end
    while (cyc < 20) begin
      tick;
      tests++;
      if (oled_res !== 1'(!(cyc >= 12 && cyc <= 15))) begin
        fails++;
        $display("FAIL res_c%0d: got %b expected %b", cyc, oled_res, !(cyc >= 12 && cyc <= 15));
      end
    end
  endtask

  task run_init;
    int vf, nat;
    vf = -1;
    nat = -1;
    while (!init_done && cyc < 1000) begin
      tick;
      if (vf < 0 && !oled_vbat) begin vf = cyc; nat = bytes.size(); end
    end
    tests++;
    if (cyc !== 369) begin fails++; $display("FAIL init_done_cycle: got %0d expected 369", cyc); end
    tests++;
    if (vf !== 185) begin fails++; $display("FAIL vbat_fall_cycle: got %0d expected 185", vf); end
    tests++;
    if (nat !== 5) begin fails++; $display("FAIL bytes_before_vbat: got %0d expected 5", nat); end
    tests++;
    if (bytes.size() !== 10) begin fails++; $display("FAIL init_count: got %0d expected 10", bytes.size()); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (i >= bytes.size() || bytes[i] !== EXP_INIT[i] || dcs[i] !== 1'b0) begin
        fails++;
        $display("FAIL init_byte%0d: got %h dc %b expected %h dc 0", i,
                 i < bytes.size() ? bytes[i] : 8'hxx, i < dcs.size() ? dcs[i] : 1'bx, EXP_INIT[i]);
      end
    end
    tests++;
    if (dc_err !== 0) begin fails++; $display("FAIL init_dc_stable: got %0d changes expected 0", dc_err); end
  endtask

  task test_write;
    int lo;
    bytes.delete();
    dcs.delete();
    tests++;
    if (wr_ready !== 1'b1) begin fails++; $display("FAIL ready_idle: got %b expected 1", wr_ready); end
    wr_valid = 1'b1;
    wr_dc = 1'b1;
    wr_data = 8'hA5;
    tick;
    wr_dc = 1'b0;
    wr_data = 8'h3C;
    lo = 0;
    while (!wr_ready && lo < 100) begin lo++; tick; end
    tests++;
    if (lo !== 32) begin fails++; $display("FAIL busy_len1: got %0d expected 32", lo); end
    tick;
    wr_valid = 1'b0;
    lo = 0;
    while (!wr_ready && lo < 100) begin lo++; tick; end
    tests++;
    if (lo !== 32) begin fails++; $display("FAIL busy_len2: got %0d expected 32", lo); end
    repeat (2) tick;
    tests++;
    if (bytes.size() !== 2 || bytes[0] !== 8'hA5 || dcs[0] !== 1'b1 || bytes[1] !== 8'h3C || dcs[1] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_bytes: got %0d bytes %h/%b %h/%b expected A5/1 3C/0", bytes.size(),
               bytes.size() > 0 ? bytes[0] : 8'hxx, dcs.size() > 0 ? dcs[0] : 1'bx,
               bytes.size() > 1 ? bytes[1] : 8'hxx, dcs.size() > 1 ? dcs[1] : 1'bx);
    end
    tests++;
    if (dc_err !== 0) begin fails++; $display("FAIL write_dc_stable: got %0d changes expected 0", dc_err); end
  endtask

  task test_capture;
    int lo;
    bytes.delete();
    dcs.delete();
    wr_valid = 1'b1;
    wr_dc = 1'b1;
    wr_data = 8'h5A;
    tick;
    wr_valid = 1'b0;
    wr_dc = 1'b0;
    wr_data = 8'hFF;
    lo = 0;
    while (!wr_ready && lo < 100) begin lo++; tick; end
    repeat (2) tick;
    tests++;
    if (bytes.size() !== 1 || bytes[0] !== 8'h5A || dcs[0] !== 1'b1) begin
      fails++;
      $display("FAIL capture: got %0d bytes %h/%b expected 5A/1", bytes.size(),
               bytes.size() > 0 ? bytes[0] : 8'hxx, dcs.size() > 0 ? dcs[0] : 1'bx);
    end
  endtask

  task test_reset_mid;
    cpu_reset = 1'b1;
    repeat (2) tick;
    release_reset;
    while (cyc < 32) tick;
    tests++;
    if (oled_sclk !== 1'b0 || oled_vdd !== 1'b0) begin
      fails++;
      $display("FAIL mid_byte_pre: got sclk %b vdd %b expected 0 0", oled_sclk, oled_vdd);
    end
    cpu_reset = 1'b1;
    tick;
    tests++;
    if (outs !== RST_OUTS) begin fails++; $display("FAIL mid_byte_reset: got %b expected %b", outs, RST_OUTS); end
    repeat (2) tick;
    release_reset;
    run_init;
  endtask

  task test_off;
    int vr, vd, rdy, n;
    bytes.delete();
    dcs.delete();
    wr_valid = 1'b1;
    wr_dc = 1'b1;
    wr_data = 8'hC3;
    tick;
    wr_valid = 1'b0;
    repeat (5) tick;
    off_req = 1'b1;
    vr = -1;
    vd = -1;
    rdy = 0;
    n = 0;
    while (vd < 0 && n < 300) begin
      tick;
      n++;
      if (wr_ready) rdy++;
      if (vr < 0 && oled_vbat) vr = cyc;
      if (vd < 0 && oled_vdd) vd = cyc;
    end
    tests++;
    if (vr < 0 || vd < 0 || vd - vr !== 20) begin
      fails++;
      $display("FAIL vdd_after_vbat: got vbat@%0d vdd@%0d expected gap 20", vr, vd);
    end
    tests++;
    if (bytes.size() !== 2 || bytes[0] !== 8'hC3 || dcs[0] !== 1'b1 || bytes[1] !== 8'hAE || dcs[1] !== 1'b0) begin
      fails++;
      $display("FAIL off_bytes: got %0d bytes %h/%b %h/%b expected C3/1 AE/0", bytes.size(),
               bytes.size() > 0 ? bytes[0] : 8'hxx, dcs.size() > 0 ? dcs[0] : 1'bx,
               bytes.size() > 1 ? bytes[1] : 8'hxx, dcs.size() > 1 ? dcs[1] : 1'bx);
    end
    off_req = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'h77;
    repeat (50) begin
      tick;
      if (wr_ready) rdy++;
    end
    wr_valid = 1'b0;
    tests++;
    if (rdy !== 0) begin fails++; $display("FAIL off_ready: got %0d ready cycles expected 0", rdy); end
    tests++;
    if (oled_vdd !== 1'b1 || oled_vbat !== 1'b1 || init_done !== 1'b0 || bytes.size() !== 2) begin
      fails++;
      $display("FAIL dead_hold: got vdd %b vbat %b init_done %b bytes %0d expected 1 1 0 2",
               oled_vdd, oled_vbat, init_done, bytes.size());
    end
  endtask

  initial begin
    test_reset;
    run_init;
    test_write;
    test_capture;
    test_reset_mid;
    test_off;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oled_ctrl.md
OLED_CTRL -- requirements
Module: oled_ctrl

Interface
REQ-001 Parameter SCLK_HALF, default 5: sysclk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter T_VDD, default 100000: sysclk cycles waited after VDD enable.
REQ-003 Parameter T_RES, default 300: sysclk cycles oled_res is held low.
REQ-004 Parameter T_VBAT, default 10000000: sysclk cycles waited after VBAT enable and after VBAT disable.
REQ-005 sysclk  in  1: single clock; all logic on its rising edge.
REQ-006 cpu_reset  in  1: synchronous, active-high reset.
REQ-007 wr_valid  in  1: host has a byte to send.
REQ-008 wr_dc  in  1: 0 = command byte, 1 = display-data byte.
REQ-009 wr_data  in  8: byte to send.
REQ-010 wr_ready  out  1: controller accepts a byte this cycle.
REQ-011 off_req  in  1: level request to run the power-down sequence.
REQ-012 init_done  out  1: panel powered and initialised.
REQ-013 oled_dc, oled_res, oled_sclk, oled_sdin, oled_vbat, oled_vdd  out  1 each: panel pins; oled_vdd and oled_vbat are active-low enables.

Function
REQ-014 States SHALL be: OFF, VDD_WAIT, RES_LO, RES_HI, INIT_A, VBAT_WAIT, INIT_B, READY, PD_CMD, PD_VBAT, DEAD.
REQ-015 OFF SHALL drive oled_vdd=0 and move to VDD_WAIT on the next cycle.
REQ-016 VDD_WAIT SHALL count T_VDD cycles, then go to RES_LO.
REQ-017 RES_LO SHALL drive oled_res=0 for T_RES cycles, then go to RES_HI with oled_res=1.
REQ-018 RES_HI SHALL wait T_RES cycles, then go to INIT_A.
REQ-019 INIT_A SHALL send the command bytes AE, 8D, 14, D9, F1 in order, with dc=0.
REQ-020 After the last INIT_A byte, the controller SHALL drive oled_vbat=0 and wait T_VBAT cycles in VBAT_WAIT.
REQ-021 INIT_B SHALL send the command bytes A1, C8, DA, 20, AF, with dc=0, then enter READY.
REQ-022 Serial link: oled_sclk idles at 1.
REQ-023 Serial link: each byte is sent MSB first, one bit per SCLK period.
REQ-024 Serial link: the controller SHALL drive oled_sclk=0 and update oled_sdin together.
REQ-025 Serial link: each low and each high phase SHALL last SCLK_HALF cycles.
REQ-026 Serial link: one byte SHALL take 16*SCLK_HALF cycles.
REQ-027 oled_dc SHALL be stable for the whole byte.
REQ-028 wr_ready SHALL be 1 only when the state is READY, the shifter is idle and off_req=0.
REQ-029 A byte SHALL be accepted on a cycle where wr_valid and wr_ready are both 1.
REQ-030 After acceptance, wr_ready SHALL be 0 from the next cycle until the byte's last high phase completes.
REQ-031 wr_ready SHALL return to 1 on the cycle after the byte's last high phase completes.
REQ-032 Back-to-back accepted bytes SHALL have no idle SCLK period between them beyond that one cycle.
REQ-033 wr_data and wr_dc SHALL be captured at acceptance; later changes SHALL have no effect.
REQ-034 init_done SHALL be 1 only in READY.
REQ-035 If off_req=1 in READY while the shifter is busy, the current byte SHALL complete before the controller leaves READY.
REQ-036 Power-down, step 1: PD_CMD sends AE, with dc=0.
REQ-037 Power-down, step 2: PD_VBAT drives oled_vbat=1 and waits T_VBAT cycles.
REQ-038 Power-down, step 3: the controller SHALL drive oled_vdd=1 and enter DEAD.
REQ-039 DEAD SHALL hold until cpu_reset; off_req outside READY SHALL be ignored.
REQ-040 wr_valid outside READY SHALL be ignored, with no buffering.
REQ-041 Delay counters SHALL be 32 bits wide.
REQ-042 Each delay counter SHALL clear on every state change.
REQ-043 A wait of N cycles SHALL mean that the state is occupied for exactly N cycles.

Reset
REQ-044 While cpu_reset=1, the outputs SHALL be: oled_vdd=1, oled_vbat=1, oled_res=1, oled_sclk=1, oled_sdin=0, oled_dc=0, wr_ready=0, init_done=0.
REQ-045 Reset SHALL take effect at any point, including mid-byte and mid-wait, aborting any transfer.
REQ-046 The first cycle after reset deasserts SHALL be in OFF.

Structure
REQ-047 The state enumeration and the 10-entry init command table SHALL live in the shared package oled_pkg.
REQ-048 The serial shifter SHALL be the sub-module oled_spi_tx, with ports start, dc, data, busy, done, sclk, sdin and dc_out.
REQ-049 The sequencer, counters and handshake SHALL live in oled_ctrl.

Verification (SCLK_HALF=2, T_VDD=10, T_RES=4, T_VBAT=20)
REQ-050 Reset release -> oled_vdd falls at cycle 1; oled_res is low during cycles 12..15.
REQ-051 Init sequence -> oled_vbat falls after the 5th byte (F1); init_done rises after AF, 10 bytes of 32 cycles each; decoded bytes = AE 8D 14 D9 F1 A1 C8 DA 20 AF.
REQ-052 In READY, send {dc=1, A5} then {dc=0, 3C} with wr_valid held -> sdin bits 10100101 then 00111100; dc 1 then 0; wr_ready low for 32 cycles per byte.
REQ-053 Raise off_req mid-byte -> that byte completes; AE is sent; oled_vbat rises; oled_vdd rises 20 cycles later; DEAD is entered; wr_ready stays 0.
REQ-054 Assert cpu_reset during bit 3 of an INIT_A byte -> all outputs take their reset values on the next cycle; the full sequence restarts from OFF.
REQ-055 Change wr_data the cycle after acceptance -> the serialised byte equals the originally captured value.
